// File: rtl/gpu_pixel_writer_if.sv
// gpu_pixel_writer_if
//   Bundles the pixel stream handshake (generator -> writer) and the
//   frame-buffer SRAM write port (writer -> arbiter/SRAM) of gpu_pixel_writer.
//   master : draw-engine / arbiter side (drives pixels and grant)
//   slave  : gpu_pixel_writer side (accepts pixels, drives SRAM cycle)
//   Signals:
//     px_valid_i, px_ready_o, x_i, y_i, r_i, g_i, b_i   pixel handshake
//     sram_grant_i, sram_req_o                          arbiter handshake
//     sram_addr_o, sram_data_o, sram_ce_n_o, sram_we_n_o  async SRAM pins
interface gpu_pixel_writer_if #(
   parameter int WIDTH_BITS   = 10,
   parameter int HEIGHT_BITS  = 9,
   parameter int CHANNEL_BITS = 8,
   parameter int ADDR_BITS    = 19
);
   logic                        px_valid_i;
   logic                        px_ready_o;
   logic [WIDTH_BITS-1:0]       x_i;
   logic [HEIGHT_BITS-1:0]      y_i;
   logic [CHANNEL_BITS-1:0]     r_i;
   logic [CHANNEL_BITS-1:0]     g_i;
   logic [CHANNEL_BITS-1:0]     b_i;
   logic                        sram_grant_i;
   logic                        sram_req_o;
   logic [ADDR_BITS-1:0]        sram_addr_o;
   logic [3*CHANNEL_BITS-1:0]   sram_data_o;
   logic                        sram_ce_n_o;
   logic                        sram_we_n_o;

   modport master (
      output px_valid_i, x_i, y_i, r_i, g_i, b_i, sram_grant_i,
      input  px_ready_o, sram_req_o, sram_addr_o, sram_data_o, sram_ce_n_o, sram_we_n_o
   );

   modport slave (
      input  px_valid_i, x_i, y_i, r_i, g_i, b_i, sram_grant_i,
      output px_ready_o, sram_req_o, sram_addr_o, sram_data_o, sram_ce_n_o, sram_we_n_o
   );
endinterface

// File: rtl/gpu_pixel_writer.sv
// gpu_pixel_writer
//   Sink of the rasterizer coordinate stream. Accepted (x, y, rgb) pixels are
//   clipped against the visible area, converted to a linear frame-buffer
//   address (y*WIDTH + x), buffered in a small FIFO and written to an
//   asynchronous SRAM with a SETUP / STROBE / HOLD cycle per pixel.
//   Ports:
//     clk, n_rst     clock (rising edge), asynchronous active-low reset
//     bus            gpu_pixel_writer_if.slave: pixel handshake + SRAM port
//     flush_i        request a completion report
//     flush_done_o   one-cycle pulse: every pixel accepted before/with flush written
//     clip_o         one-cycle pulse: accepted pixel was off-screen and dropped
//     busy_o         FIFO non-empty or write cycle in progress
//     write_cnt_o    completed writes, modulo 2^ADDR_BITS
module gpu_pixel_writer #(
   parameter int WIDTH        = 640,
   parameter int HEIGHT       = 480,
   parameter int WIDTH_BITS   = 10,
   parameter int HEIGHT_BITS  = 9,
   parameter int CHANNEL_BITS = 8,
   parameter int ADDR_BITS    = 19,
   parameter int FIFO_DEPTH   = 4,
   parameter int WE_CYCLES    = 2
) (
   input  logic                 clk,
   input  logic                 n_rst,
   gpu_pixel_writer_if.slave    bus,
   input  logic                 flush_i,
   output logic                 flush_done_o,
   output logic                 clip_o,
   output logic                 busy_o,
   output logic [ADDR_BITS-1:0] write_cnt_o
);
   localparam int DATA_BITS = 3 * CHANNEL_BITS;
   localparam int PTR_BITS  = $clog2(FIFO_DEPTH);
   localparam int CNT_BITS  = PTR_BITS + 1;
   localparam int WE_BITS   = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
   localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
   localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(FIFO_DEPTH);
   localparam logic [WE_BITS-1:0]  WE_LAST  = WE_BITS'(WE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2, HOLD = 2'd3} state_t;

   state_t                 state_r, state_s;
   logic [ADDR_BITS-1:0]   addr_mem_r [FIFO_DEPTH];
   logic [DATA_BITS-1:0]   data_mem_r [FIFO_DEPTH];
   logic [PTR_BITS-1:0]    wr_ptr_r, rd_ptr_r;
   logic [CNT_BITS-1:0]    count_r, count_s;
   logic [WE_BITS-1:0]     we_cnt_r;
   logic [ADDR_BITS-1:0]   addr_r, enq_addr_s, wcnt_r;
   logic [DATA_BITS-1:0]   data_r;
   logic                   accept_s, in_range_s, push_s, pop_s;
   logic                   ce_n_s, we_n_s, ce_n_r, we_n_r;
   logic                   ready_r, req_r, clip_r, pend_r, pend_s, fire_s, done_r;

   // Handshake, clipping and address generation at enqueue time; the
   // operands are widened to ADDR_BITS so the product is never truncated.
   assign accept_s   = bus.px_valid_i && ready_r;
   assign in_range_s = (32'(bus.x_i) < WIDTH) && (32'(bus.y_i) < HEIGHT);
   assign push_s     = accept_s && in_range_s;
   assign enq_addr_s = ADDR_BITS'(bus.y_i) * ADDR_BITS'(WIDTH) + ADDR_BITS'(bus.x_i);
   assign count_s    = count_r + {{PTR_BITS{1'b0}}, push_s} - {{PTR_BITS{1'b0}}, pop_s};

   // A flush covers a pixel accepted on the same edge because the completion
   // test looks at the post-edge FIFO count and state.
   assign pend_s = pend_r || flush_i;
   assign fire_s = pend_s && (count_s == CNT_ZERO) && (state_s == IDLE);

   // FSM state register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_r <= IDLE;
      else        state_r <= state_s;
   end

   // FSM next state; grant is only looked at in IDLE and HOLD
   always_comb begin
      state_s = state_r;
      pop_s   = 1'b0;
      case (state_r)
         IDLE, HOLD: begin
            if ((count_r != CNT_ZERO) && bus.sram_grant_i) begin
               pop_s   = 1'b1;
               state_s = SETUP;
            end else begin
               state_s = IDLE;
            end
         end
         SETUP:   state_s = STROBE;
         STROBE: begin
            if (we_cnt_r == WE_LAST) state_s = HOLD;
            else                     state_s = STROBE;
         end
         default: state_s = IDLE;
      endcase
   end

   // FSM outputs, decoded from the next state so the strobes can be registered
   always_comb begin
      ce_n_s = 1'b1;
      we_n_s = 1'b1;
      case (state_s)
         IDLE:        begin ce_n_s = 1'b1; we_n_s = 1'b1; end
         SETUP, HOLD: begin ce_n_s = 1'b0; we_n_s = 1'b1; end
         STROBE:      begin ce_n_s = 1'b0; we_n_s = 1'b0; end
         default:     begin ce_n_s = 1'b1; we_n_s = 1'b1; end
      endcase
   end

   // FIFO storage; contents need no reset since the count gates every read
   always_ff @(posedge clk) begin
      if (push_s) begin
         addr_mem_r[wr_ptr_r] <= enq_addr_s;
         data_mem_r[wr_ptr_r] <= {bus.r_i, bus.g_i, bus.b_i};
      end
   end

   // FIFO pointers, write-cycle datapath and status registers
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr_r <= {PTR_BITS{1'b0}};
         rd_ptr_r <= {PTR_BITS{1'b0}};
         count_r  <= CNT_ZERO;
         we_cnt_r <= {WE_BITS{1'b0}};
         addr_r   <= {ADDR_BITS{1'b0}};
         data_r   <= {DATA_BITS{1'b0}};
         wcnt_r   <= {ADDR_BITS{1'b0}};
         ce_n_r   <= 1'b1;
         we_n_r   <= 1'b1;
         ready_r  <= 1'b1;
         req_r    <= 1'b0;
         clip_r   <= 1'b0;
         pend_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_BITS'(1'b1);
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_BITS'(1'b1);
            addr_r   <= addr_mem_r[rd_ptr_r];
            data_r   <= data_mem_r[rd_ptr_r];
         end
         count_r  <= count_s;
         we_cnt_r <= (state_r == STROBE) ? (we_cnt_r + WE_BITS'(1'b1)) : {WE_BITS{1'b0}};
         if (state_r == HOLD) wcnt_r <= wcnt_r + ADDR_BITS'(1'b1);
         ce_n_r   <= ce_n_s;
         we_n_r   <= we_n_s;
         // Ready follows the post-edge count, so a pop while full frees a
         // slot one cycle later rather than passing through combinationally.
         ready_r  <= (count_s != CNT_FULL);
         req_r    <= (count_s != CNT_ZERO) || (state_s != IDLE);
         clip_r   <= accept_s && !in_range_s;
         pend_r   <= pend_s && !fire_s;
         done_r   <= fire_s;
      end
   end

   assign bus.px_ready_o  = ready_r;
   assign bus.sram_req_o  = req_r;
   assign bus.sram_addr_o = addr_r;
   assign bus.sram_data_o = data_r;
   assign bus.sram_ce_n_o = ce_n_r;
   assign bus.sram_we_n_o = we_n_r;
   assign busy_o          = req_r;
   assign clip_o          = clip_r;
   assign flush_done_o    = done_r;
   assign write_cnt_o     = wcnt_r;
endmodule

// File: tb/tb_gpu_pixel_writer.sv
// tb_gpu_pixel_writer
//   Directed bench for gpu_pixel_writer at default parameters. A negedge
//   monitor logs each completed SRAM write (address, data, we_n low length,
//   cycle) and counts clip / flush_done pulses and ce_n activity.
module tb_gpu_pixel_writer;
   logic        clk = 1'b0;
   logic        n_rst;
   logic        flush_i;
   logic        flush_done_o;
   logic        clip_o;
   logic        busy_o;
   logic [18:0] write_cnt_o;

   gpu_pixel_writer_if bus ();

   gpu_pixel_writer dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .bus          (bus),
      .flush_i      (flush_i),
      .flush_done_o (flush_done_o),
      .clip_o       (clip_o),
      .busy_o       (busy_o),
      .write_cnt_o  (write_cnt_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int log_n = 0, low_cnt = 0, ce_cyc = 0, clip_n = 0, done_n = 0, rdy_low = 0, cyc = 0;
   logic [18:0] log_addr [64];
   logic [23:0] log_data [64];
   int          log_len  [64];
   int          log_start[64];

   // Monitor: log a write when we_n returns high (HOLD keeps addr/data stable)
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (!n_rst) begin
         low_cnt <= 0;
      end else begin
         if (!bus.sram_we_n_o) begin
            low_cnt <= low_cnt + 1;
         end else if (low_cnt != 0) begin
            log_addr[log_n]  <= bus.sram_addr_o;
            log_data[log_n]  <= bus.sram_data_o;
            log_len[log_n]   <= low_cnt;
            log_start[log_n] <= cyc;
            log_n            <= log_n + 1;
            low_cnt          <= 0;
         end
         if (!bus.sram_ce_n_o) ce_cyc  <= ce_cyc + 1;
         if (clip_o)           clip_n  <= clip_n + 1;
         if (flush_done_o)     done_n  <= done_n + 1;
         if (!bus.px_ready_o)  rdy_low <= rdy_low + 1;
      end
   end

   task automatic send(input logic [9:0] x, input logic [8:0] y, input logic [23:0] c, input logic fl);
      int t;
      t = 0;
      @(negedge clk);
      bus.px_valid_i = 1'b1;
      bus.x_i = x;
      bus.y_i = y;
      {bus.r_i, bus.g_i, bus.b_i} = c;
      flush_i = fl;
      while (!bus.px_ready_o && t < 50) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk);
      #1;
      bus.px_valid_i = 1'b0;
      flush_i = 1'b0;
   endtask

   task automatic wait_wc(input logic [18:0] tgt);
      int t;
      t = 0;
      while (write_cnt_o !== tgt && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      flush_i = 1'b0;
      bus.px_valid_i = 1'b0;
      bus.x_i = 10'd0;
      bus.y_i = 9'd0;
      bus.r_i = 8'd0;
      bus.g_i = 8'd0;
      bus.b_i = 8'd0;
      bus.sram_grant_i = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.px_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.px_ready_o); end
      checks++; if (bus.sram_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", bus.sram_req_o); end
      checks++; if (bus.sram_ce_n_o !== 1'b1 || bus.sram_we_n_o !== 1'b1) begin errors++; $display("FAIL rst_strobes got ce_n=%b we_n=%b exp 1 1", bus.sram_ce_n_o, bus.sram_we_n_o); end
      checks++; if (bus.sram_addr_o !== 19'd0 || bus.sram_data_o !== 24'd0) begin errors++; $display("FAIL rst_addr_data got %h %h exp 0 0", bus.sram_addr_o, bus.sram_data_o); end
      checks++; if (busy_o !== 1'b0 || clip_o !== 1'b0 || flush_done_o !== 1'b0) begin errors++; $display("FAIL rst_flags got busy=%b clip=%b done=%b exp 0 0 0", busy_o, clip_o, flush_done_o); end
      checks++; if (write_cnt_o !== 19'd0) begin errors++; $display("FAIL rst_wcnt got %0d exp 0", write_cnt_o); end
      n_rst = 1'b1;
   endtask

   task automatic test_single();
      int k;
      bus.sram_grant_i = 1'b1;
      send(10'd3, 9'd2, 24'h112233, 1'b0);
      // just after transfer edge N: FIFO holds one pixel, FSM still IDLE
      checks++; if (bus.sram_req_o !== 1'b1 || bus.sram_ce_n_o !== 1'b1) begin errors++; $display("FAIL single_n got req=%b ce_n=%b exp 1 1", bus.sram_req_o, bus.sram_ce_n_o); end
      @(posedge clk); #1;
      // after N+1: SETUP with address already presented, we_n high
      checks++; if (bus.sram_ce_n_o !== 1'b0 || bus.sram_we_n_o !== 1'b1 || bus.sram_addr_o !== 19'd1283) begin errors++; $display("FAIL single_setup got ce_n=%b we_n=%b addr=%0d exp 0 1 1283", bus.sram_ce_n_o, bus.sram_we_n_o, bus.sram_addr_o); end
      k = 1;
      while (write_cnt_o !== 19'd1 && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      checks++; if (k !== 5) begin errors++; $display("FAIL single_latency got %0d exp 5 edges", k); end
      @(negedge clk); @(negedge clk);
      checks++; if (log_n !== 1) begin errors++; $display("FAIL single_count got %0d exp 1 writes", log_n); end
      checks++; if (log_addr[0] !== 19'd1283) begin errors++; $display("FAIL single_addr got %0d exp 1283", log_addr[0]); end
      checks++; if (log_data[0] !== 24'h112233) begin errors++; $display("FAIL single_data got %h exp 112233", log_data[0]); end
      checks++; if (log_len[0] !== 2) begin errors++; $display("FAIL single_we_len got %0d exp 2", log_len[0]); end
      checks++; if (write_cnt_o !== 19'd1 || busy_o !== 1'b0) begin errors++; $display("FAIL single_end got wcnt=%0d busy=%b exp 1 0", write_cnt_o, busy_o); end
   endtask

   task automatic test_burst();
      int b;
      logic [18:0] w0;
      b = log_n;
      w0 = write_cnt_o;
      for (int i = 0; i < 8; i++) begin
         send(10'(i), 9'd479, {8'(i), 8'hA0, 8'h55}, 1'b0);
         if (i == 3) begin
            checks++; if (bus.px_ready_o !== 1'b1) begin errors++; $display("FAIL burst_ready3 got %b exp 1", bus.px_ready_o); end
         end
         if (i == 4) begin
            checks++; if (bus.px_ready_o !== 1'b0) begin errors++; $display("FAIL burst_full got %b exp 0", bus.px_ready_o); end
         end
      end
      wait_wc(w0 + 19'd8);
      @(negedge clk); @(negedge clk);
      checks++; if (write_cnt_o !== w0 + 19'd8) begin errors++; $display("FAIL burst_wcnt got %0d exp %0d", write_cnt_o, w0 + 19'd8); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (log_addr[b+i] !== 19'(306560 + i) || log_data[b+i] !== {8'(i), 8'hA0, 8'h55} || log_len[b+i] !== 2) begin
            errors++; $display("FAIL burst_write%0d got addr=%0d data=%h len=%0d exp %0d %h 2", i, log_addr[b+i], log_data[b+i], log_len[b+i], 306560 + i, {8'(i), 8'hA0, 8'h55});
         end
         if (i > 0) begin
            checks++; if (log_start[b+i] - log_start[b+i-1] !== 4) begin errors++; $display("FAIL burst_spacing%0d got %0d exp 4", i, log_start[b+i] - log_start[b+i-1]); end
         end
      end
   endtask

   task automatic test_clip();
      int c0, e0, b;
      logic [18:0] w0;
      c0 = clip_n;
      e0 = ce_cyc;
      w0 = write_cnt_o;
      send(10'd640, 9'd0, 24'hDEAD01, 1'b0);
      checks++; if (clip_o !== 1'b1) begin errors++; $display("FAIL clip_x_pulse got %b exp 1", clip_o); end
      send(10'd0, 9'd480, 24'hDEAD02, 1'b0);
      checks++; if (clip_o !== 1'b1) begin errors++; $display("FAIL clip_y_pulse got %b exp 1", clip_o); end
      repeat (6) @(negedge clk);
      checks++; if (clip_n - c0 !== 2) begin errors++; $display("FAIL clip_count got %0d exp 2", clip_n - c0); end
      checks++; if (ce_cyc !== e0 || write_cnt_o !== w0 || busy_o !== 1'b0) begin errors++; $display("FAIL clip_no_sram got ce_cycles=%0d wcnt=%0d busy=%b exp %0d %0d 0", ce_cyc - e0, write_cnt_o, busy_o, 0, w0); end
      // last visible pixel is in range and maps to the top address
      b = log_n;
      send(10'd639, 9'd479, 24'hABCDEF, 1'b0);
      wait_wc(w0 + 19'd1);
      @(negedge clk); @(negedge clk);
      checks++; if (log_addr[b] !== 19'd307199 || log_data[b] !== 24'hABCDEF || clip_n - c0 !== 2) begin errors++; $display("FAIL clip_max_pixel got addr=%0d data=%h clips=%0d exp 307199 abcdef 2", log_addr[b], log_data[b], clip_n - c0); end
   endtask

   task automatic test_grant();
      int e0, b;
      logic [18:0] w0;
      bus.sram_grant_i = 1'b0;
      e0 = ce_cyc;
      w0 = write_cnt_o;
      b = log_n;
      send(10'd10, 9'd1, 24'h0A0B0C, 1'b0);
      send(10'd11, 9'd1, 24'h0D0E0F, 1'b0);
      repeat (3) @(negedge clk);
      checks++; if (ce_cyc !== e0 || bus.sram_req_o !== 1'b1) begin errors++; $display("FAIL grant_wait got ce_cycles=%0d req=%b exp 0 1", ce_cyc - e0, bus.sram_req_o); end
      bus.sram_grant_i = 1'b1;
      @(negedge clk);
      bus.sram_grant_i = 1'b0;
      repeat (10) @(negedge clk);
      checks++; if (write_cnt_o !== w0 + 19'd1 || log_n !== b + 1) begin errors++; $display("FAIL grant_one got wcnt=%0d writes=%0d exp %0d %0d", write_cnt_o, log_n - b, w0 + 19'd1, 1); end
      checks++; if (log_addr[b] !== 19'd650 || log_len[b] !== 2) begin errors++; $display("FAIL grant_first got addr=%0d len=%0d exp 650 2", log_addr[b], log_len[b]); end
      checks++; if (bus.sram_ce_n_o !== 1'b1 || bus.sram_req_o !== 1'b1) begin errors++; $display("FAIL grant_parked got ce_n=%b req=%b exp 1 1", bus.sram_ce_n_o, bus.sram_req_o); end
      bus.sram_grant_i = 1'b1;
      wait_wc(w0 + 19'd2);
      @(negedge clk); @(negedge clk);
      checks++; if (log_n !== b + 2 || log_addr[b+1] !== 19'd651 || log_data[b+1] !== 24'h0D0E0F) begin errors++; $display("FAIL grant_second got writes=%0d addr=%0d data=%h exp 2 651 0d0e0f", log_n - b, log_addr[b+1], log_data[b+1]); end
   endtask

   task automatic test_flush();
      int d0, t;
      logic [18:0] w0;
      bus.sram_grant_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      checks++; if (flush_done_o !== 1'b1) begin errors++; $display("FAIL flush_idle got %b exp 1", flush_done_o); end
      @(posedge clk); #1;
      checks++; if (flush_done_o !== 1'b0) begin errors++; $display("FAIL flush_idle_end got %b exp 0", flush_done_o); end
      @(negedge clk);
      d0 = done_n;
      w0 = write_cnt_o;
      send(10'd20, 9'd5, 24'h010101, 1'b0);
      send(10'd21, 9'd5, 24'h020202, 1'b0);
      send(10'd22, 9'd5, 24'h030303, 1'b1);
      checks++; if (flush_done_o !== 1'b0) begin errors++; $display("FAIL flush_early got %b exp 0", flush_done_o); end
      t = 0;
      while (write_cnt_o !== w0 + 19'd3 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      checks++; if (flush_done_o !== 1'b1 || done_n !== d0) begin errors++; $display("FAIL flush_after_hold got done=%b prior_pulses=%0d exp 1 0", flush_done_o, done_n - d0); end
      repeat (4) @(negedge clk);
      checks++; if (done_n - d0 !== 1 || flush_done_o !== 1'b0) begin errors++; $display("FAIL flush_once got pulses=%0d done=%b exp 1 0", done_n - d0, flush_done_o); end
   endtask

   task automatic test_reset_mid();
      int t, e0, b;
      bus.sram_grant_i = 1'b1;
      b = log_n;
      send(10'd30, 9'd7, 24'h777777, 1'b0);
      send(10'd31, 9'd7, 24'h888888, 1'b0);
      t = 0;
      while (bus.sram_we_n_o !== 1'b0 && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      checks++; if (bus.sram_we_n_o !== 1'b0) begin errors++; $display("FAIL rmid_strobe got we_n=%b exp 0", bus.sram_we_n_o); end
      #1;
      n_rst = 1'b0;
      #1;
      checks++; if (bus.sram_we_n_o !== 1'b1 || bus.sram_ce_n_o !== 1'b1) begin errors++; $display("FAIL rmid_async got ce_n=%b we_n=%b exp 1 1", bus.sram_ce_n_o, bus.sram_we_n_o); end
      @(negedge clk);
      #1;
      n_rst = 1'b1;
      e0 = ce_cyc;
      repeat (10) @(negedge clk);
      checks++; if (busy_o !== 1'b0 || bus.px_ready_o !== 1'b1 || bus.sram_req_o !== 1'b0) begin errors++; $display("FAIL rmid_state got busy=%b ready=%b req=%b exp 0 1 0", busy_o, bus.px_ready_o, bus.sram_req_o); end
      checks++; if (write_cnt_o !== 19'd0 || ce_cyc !== e0 || log_n !== b) begin errors++; $display("FAIL rmid_discard got wcnt=%0d ce_cycles=%0d writes=%0d exp 0 0 0", write_cnt_o, ce_cyc - e0, log_n - b); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_clip();
      test_grant();
      test_flush();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/gpu_pixel_writer.md
# gpu_pixel_writer

Sink end of the rasterizer coordinate stream. Accepts (x, y, colour) pixels from a generator such as the fill-rect engine through a valid/ready handshake, buffers them in a small FIFO, converts each to a linear frame-buffer address, and performs an asynchronous-SRAM write cycle per pixel. Sits between the draw engines and the frame-buffer SRAM port, behind the memory arbiter shared with scan-out.

## Interface
Parameters:
- WIDTH, 640, visible pixels per line
- HEIGHT, 480, visible lines
- WIDTH_BITS, 10, x coordinate width
- HEIGHT_BITS, 9, y coordinate width
- CHANNEL_BITS, 8, bits per colour channel
- ADDR_BITS, 19, SRAM word address width
- FIFO_DEPTH, 4, pixel FIFO entries (power of two, ≥2)
- WE_CYCLES, 2, cycles sram_we_n_o is held low (≥1)

Ports:
- clk  in  1  clock, rising edge
- n_rst  in  1  reset, asynchronous, active-low
- px_valid_i  in  1  pixel offered
- px_ready_o  out  1  FIFO can accept
- x_i  in  WIDTH_BITS  pixel column
- y_i  in  HEIGHT_BITS  pixel row
- r_i, g_i, b_i  in  CHANNEL_BITS each  pixel colour
- flush_i  in  1  request completion report
- flush_done_o  out  1  one-cycle pulse: all prior pixels written
- clip_o  out  1  one-cycle pulse: accepted pixel discarded as off-screen
- sram_grant_i  in  1  arbiter permits a new write cycle
- sram_req_o  out  1  write cycle wanted or in progress
- sram_addr_o  out  ADDR_BITS  word address
- sram_data_o  out  3*CHANNEL_BITS  {r, g, b}
- sram_ce_n_o  out  1  chip enable, active-low
- sram_we_n_o  out  1  write enable, active-low
- busy_o  out  1  FIFO non-empty or FSM not IDLE
- write_cnt_o  out  ADDR_BITS  completed writes

## Operation
- Transfer occurs on a rising edge with px_valid_i && px_ready_o. px_ready_o = FIFO not full (registered state only; no combinational path from px_valid_i).
- Clipping: x_i ≥ WIDTH or y_i ≥ HEIGHT → pixel accepted, not enqueued, clip_o pulses the following cycle.
- Address = y*WIDTH + x, computed at enqueue, stored in FIFO with {r,g,b}; full ADDR_BITS width, no truncation for in-range pixels (max 307199).
- FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE: FIFO non-empty && sram_grant_i → pop head into addr/data output registers, go SETUP.
  - SETUP: ce_n low, we_n high, 1 cycle → STROBE.
  - STROBE: ce_n low, we_n low for WE_CYCLES cycles (internal counter) → HOLD.
  - HOLD: we_n high, ce_n low, addr/data unchanged, 1 cycle; write_cnt_o increments; then same test as IDLE (back-to-back to SETUP with pop) else IDLE.
- sram_grant_i is sampled only in IDLE/HOLD; deassertion during SETUP/STROBE does not abort the cycle.
- sram_req_o = FIFO non-empty or state ≠ IDLE.
- Flush: flush_i sets a pending flag; flush_done_o pulses on the first cycle in which the flag is set, FIFO is empty and state is IDLE; flag clears with the pulse. A pixel transferred on the same edge as flush_i is covered by that flush. Repeated flush_i while pending is ignored.
- write_cnt_o wraps modulo 2^ADDR_BITS.

## Timing
- Reset values: px_ready_o 1, flush_done_o 0, clip_o 0, sram_req_o 0, sram_addr_o 0, sram_data_o 0, sram_ce_n_o 1, sram_we_n_o 1, busy_o 0, write_cnt_o 0; FIFO empty, FSM IDLE, flush flag clear.
- Reset mid-write: ce_n/we_n go high asynchronously; FIFO contents and pending flush discarded.
- Latency, empty FIFO, grant high: transfer at edge N → SETUP after edge N+1 → we_n low after edge N+2 → write_cnt_o updated after edge N+3+WE_CYCLES.
- Throughput: one pixel per WE_CYCLES+2 cycles (4 at default).
- FIFO full with simultaneous pop: px_ready_o rises the cycle after the pop (no same-cycle pass-through).
- Address/data stable from SETUP through HOLD inclusive; we_n never low in SETUP or HOLD.

## Test plan
- Single pixel (x=3, y=2, rgb=0x112233), grant high → one write: addr 1283, data 0x112233, we_n low exactly 2 cycles, write_cnt_o=1.
- Burst of 8 pixels x=0..7, y=479, valid held → px_ready_o drops after 4 buffered, writes at addr 306560..306567 in order, one per 4 cycles.
- Pixel x=640, y=0 then x=0, y=480 → two clip_o pulses, no SRAM activity, write_cnt_o unchanged.
- Grant low with 2 queued, raise for 1 cycle then drop mid-SETUP → first write completes fully, second waits until grant returns.
- flush_i on the same edge as the 3rd of 3 pixels → flush_done_o pulses once, only after the 3rd write's HOLD; flush while idle/empty pulses next cycle.
- n_rst asserted during STROBE → we_n/ce_n high immediately; after release, busy_o=0, px_ready_o=1, write_cnt_o=0.
